// File: rtl/tamaguchi_pkg.sv
// Shared constants for the tamaguchi input front end: default timings,
// button indices and counter-width helpers.
package tamaguchi_pkg;

  localparam int DEF_CLK_FREQ        = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 250_000_000;

  localparam int NUM_BTN = 4;
  localparam int DORMIR  = 0;
  localparam int JUGAR   = 1;
  localparam int COMER   = 2;
  localparam int TEST    = 3;

  localparam int DB_MIN_W   = 1;
  localparam int HOLD_MIN_W = 28;
  localparam int SEC_MIN_W  = 26;

  // Bits needed to hold 0..n-1, never narrower than min_w.
  function automatic int cnt_width(input int n, input int min_w);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return (w > min_w) ? w : min_w;
  endfunction

endpackage

// File: rtl/botones_entrada_antirrebote.sv
// One pushbutton: 2-flop synchronizer, stability-counter debounce,
// press edge pulse and long-press detection.
module antirrebote
  import tamaguchi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic long_o,
  output logic held_o
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES, DB_MIN_W);
  localparam int HOLD_W = cnt_width(LONG_CYCLES, HOLD_MIN_W);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        sync_q, sync_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic              held_q, held_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    sync_d   = {sync_q[0], ~btn_n_i};
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) level_d  = ~level_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end

    press_d = level_d & ~level_q;

    hold_d = '0;
    if (level_q) hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;

    // Gated by level_d so a release on the saturating edge cannot fire.
    long_d = level_d && (hold_d == HOLD_LAST) && (hold_q != HOLD_LAST);
    held_d = level_d & (held_q | long_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      hold_q   <= '0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      long_q   <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      hold_q   <= hold_d;
      level_q  <= level_d;
      press_q  <= press_d;
      long_q   <= long_d;
      held_q   <= held_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;
  assign long_o  = long_q;
  assign held_o  = held_q;

endmodule

// File: rtl/botones_entrada.sv
// Tamaguchi button front end: four debounced buttons with press and
// long-press events, plus a free-running one-second tick.
module botones_entrada
  import tamaguchi_pkg::*;
#(
  parameter int CLK_FREQ        = DEF_CLK_FREQ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic               boton_dormir,
  output logic               boton_jugar,
  output logic               boton_comer,
  output logic               test,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] long_press,
  output logic [NUM_BTN-1:0] held_long,
  output logic               secondpassed
);

  localparam int SEC_W = cnt_width(CLK_FREQ, SEC_MIN_W);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_FREQ - 1);

  logic [NUM_BTN-1:0] level;
  logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
  logic               sec_tick_q, sec_tick_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_antirrebote (
      .clk    (clk),
      .reset  (reset),
      .btn_n_i(btn_n[i]),
      .level_o(level[i]),
      .press_o(press[i]),
      .long_o (long_press[i]),
      .held_o (held_long[i])
    );
  end

  always_comb begin
    sec_cnt_d  = (sec_cnt_q == SEC_LAST) ? '0 : sec_cnt_q + 1'b1;
    sec_tick_d = (sec_cnt_q == SEC_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt_q  <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_cnt_q  <= sec_cnt_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign boton_dormir = level[DORMIR];
  assign boton_jugar  = level[JUGAR];
  assign boton_comer  = level[COMER];
  assign test         = level[TEST];
  assign secondpassed = sec_tick_q;

endmodule

// File: tb/tb_botones_entrada.sv
// Scoreboard bench for botones_entrada: expected output vectors are queued
// per cycle when stimulus is planned and compared as the DUT is sampled.
module tb_botones_entrada;

  localparam int CLKF = 10;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int LAT  = 2 + DEB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       boton_dormir, boton_jugar, boton_comer, test;
  logic [3:0] press, long_press, held_long;
  logic       secondpassed;

  botones_entrada #(
    .CLK_FREQ       (CLKF),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_n       (btn_n),
    .boton_dormir(boton_dormir),
    .boton_jugar (boton_jugar),
    .boton_comer (boton_comer),
    .test        (test),
    .press       (press),
    .long_press  (long_press),
    .held_long   (held_long),
    .secondpassed(secondpassed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   sched_cyc = 0;

  // {levels, press, long_press, held_long, secondpassed}
  function automatic logic [16:0] observed();
    return {test, boton_comer, boton_jugar, boton_dormir,
            press, long_press, held_long, secondpassed};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Queue the expectation for the next clock edge; the tick expectation
  // follows from the edge count since reset release.
  task automatic push_exp(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                          input logic [3:0] lng, input logic [3:0] hld);
    exp_t e;
    sched_cyc++;
    e.tag = $sformatf("%s@%0d", tag, sched_cyc);
    e.v   = {lvl, prs, lng, hld, (sched_cyc % CLKF == 0)};
    sb_q.push_back(e);
  endtask

  // Drive one raw value, advance one edge, compare against the scoreboard.
  task automatic step(input logic [3:0] raw);
    exp_t e;
    btn_n = raw;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", observed(), 17'h1FFFF);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, observed(), e.v);
    end
  endtask

  // Buttons in mask go low for hold_len cycles; expected timing from the
  // raw edge: level after LAT, long press LONG-1 after that.
  task automatic press_test(input string tag, input logic [3:0] mask,
                            input int hold_len, input int n_steps);
    int long_at, fall_at;
    logic on, is_long;
    long_at = LAT + LONG - 1;
    fall_at = hold_len + LAT;
    is_long = (long_at < fall_at);
    for (int s = 1; s <= n_steps; s++) begin
      on = (s >= LAT) && (s < fall_at);
      push_exp(tag, on ? mask : 4'h0,
               (s == LAT) ? mask : 4'h0,
               (is_long && s == long_at) ? mask : 4'h0,
               (is_long && on && s >= long_at) ? mask : 4'h0);
    end
    for (int s = 1; s <= n_steps; s++) step((s <= hold_len) ? ~mask : 4'hF);
  endtask

  initial begin
    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset", observed(), 17'h0);
    reset = 1'b0;
    sched_cyc = 0;

    // Free-running tick with idle buttons.
    for (int s = 1; s <= 35; s++) push_exp("tick", 4'h0, 4'h0, 4'h0, 4'h0);
    for (int s = 1; s <= 35; s++) step(4'hF);

    // Clean long press on comer.
    press_test("comer", 4'b0100, 30, 40);

    // Bounce on dormir: 2-cycle runs never reach the debounce threshold.
    for (int s = 1; s <= 20; s++) push_exp("bounce", 4'h0, 4'h0, 4'h0, 4'h0);
    for (int s = 1; s <= 20; s++) step((s <= 12 && ((s - 1) % 4) < 2) ? 4'b1110 : 4'hF);

    // Short press on jugar.
    press_test("short", 4'b0010, 10, 20);

    // Reset while test is held and debounced high for 15 cycles.
    press_test("pre_rst", 4'b1000, 1000, LAT + 14);
    reset = 1'b1;
    #1;
    check("rst_async", observed(), 17'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", observed(), 17'h0);
    reset = 1'b0;
    sched_cyc = 0;
    press_test("post_rst", 4'b1000, 30, 40);

    // All four buttons together.
    press_test("all", 4'b1111, 30, 40);

    check("sb_drained", 17'(sb_q.size()), 17'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/botones_entrada.md
BOTONES_ENTRADA -- requirements
Module: botones_entrada

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_FREQ, 50000000, clock cycles per secondpassed period.
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a debounced level changes.
- LONG_CYCLES, 250000000, debounced-press cycles needed to count as a long press.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, the single system clock.
- reset, input, 1, asynchronous active-high reset.
- btn_n, input, 4, raw active-low pushbuttons, asynchronous to clk: [0] dormir, [1] jugar, [2] comer, [3] test.
- boton_dormir, boton_jugar, boton_comer, test, output, 1 each, debounced active-high levels.
- press, output, 4, one-cycle pulse on each debounced press; same bit order as btn_n.
- long_press, output, 4, one-cycle pulse when a debounced press reaches LONG_CYCLES.
- held_long, output, 4, level that stays high from the long_press pulse until the debounced release.
- secondpassed, output, 1, one-cycle tick every CLK_FREQ cycles.

Function
REQ-003 Each btn_n bit SHALL be inverted and passed through a 2-flip-flop synchronizer before any other use.
REQ-004 Each button SHALL own a stability counter:
- The counter increments while the synchronized value differs from the debounced level.
- It clears to 0 whenever the synchronized value equals the debounced level.
REQ-005 When a stability counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced level SHALL toggle on the next edge and the counter SHALL clear.
REQ-006 Latency from a clean raw edge to the debounced level change SHALL be exactly 2+DEBOUNCE_CYCLES clk cycles.
REQ-007 A bounce (any return to the old value) before DEBOUNCE_CYCLES SHALL restart the count with no output change.
REQ-008 press[i] SHALL pulse high for exactly one cycle, in the same cycle the debounced level i rises.
REQ-009 Nothing SHALL pulse on a debounced fall.
REQ-010 Each button SHALL own a 28-bit hold counter:
- It clears while the debounced level is low.
- It increments while the level is high.
- It saturates at LONG_CYCLES-1.
REQ-011 long_press[i] SHALL pulse once, in the cycle the hold counter first reaches LONG_CYCLES-1.
REQ-012 held_long[i] SHALL set together with long_press[i] and clear in the cycle the debounced level falls.
REQ-013 A press released before LONG_CYCLES SHALL produce no long_press pulse.
REQ-014 A held button SHALL never re-trigger long_press.
REQ-015 secondpassed SHALL come from a free-running counter:
- The counter counts 0..CLK_FREQ-1 and wraps to 0.
- secondpassed is high only in the cycle the counter equals CLK_FREQ-1.
- The counter is independent of the buttons.
REQ-016 The four buttons SHALL be fully independent, so simultaneous presses each produce their own press and long_press pulses in the same cycles.
REQ-017 All outputs SHALL be registered.
REQ-018 Counter comparisons SHALL never overflow:
- Widths are sized from the parameters.
- The hold counter is 28 bits minimum.
- The second counter is 26 bits minimum at the default CLK_FREQ.

Reset
REQ-019 While reset is high, all synchronizer flip-flops, debounced levels, counters, press, long_press, held_long and secondpassed SHALL be 0.
REQ-020 Reset SHALL take effect asynchronously and be released synchronously to clk.
REQ-021 A button held through reset release SHALL be treated as a new press:
- It is debounced again from zero.
- After 2+DEBOUNCE_CYCLES cycles, press pulses once.
REQ-022 Reset in the middle of a debounce or a hold SHALL abort it, with no pulse afterwards unless the full timing is met again.

Structure
REQ-023 Default parameter values, the button index constants (DORMIR=0, JUGAR=1, COMER=2, TEST=3) and counter widths SHALL live in the shared tamaguchi constants package.
REQ-024 One sub-module, antirrebote, SHALL implement synchronizer, debounce, press edge and long-press detection for one button.
- It is instantiated four times.
- The top level adds the secondpassed counter and the output mapping.

Verification
Run all benches with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CLK_FREQ=10.
REQ-025 Clean press: btn_n[2] falls and is held 30 cycles, then rises. Required response:
- boton_comer rises 6 cycles after the fall.
- press[2] pulses once in that same cycle.
- long_press[2] pulses 19 cycles later.
- held_long[2] falls 6 cycles after the raw rise.
REQ-026 Bounce: btn_n[0] toggles low/high every 2 cycles for 12 cycles, then stays high. Required response: boton_dormir, press[0] and long_press[0] stay 0 throughout.
REQ-027 Short press: btn_n[1] held low for 10 cycles. Required response:
- press[1] pulses once.
- long_press[1] stays 0.
- held_long[1] stays 0.
REQ-028 Tick: reset is released and the bench runs 35 cycles. Required response: secondpassed is high in exactly 3 cycles, spaced 10 apart, the first on the 10th cycle after release.
REQ-029 Reset mid-hold: btn_n[3] held low, reset pulsed after 15 debounced-high cycles with the button still held. Required response:
- test drops to 0 immediately.
- test re-rises 6 cycles after reset release.
- long_press[3] pulses 19 cycles after that, never before.
REQ-030 Simultaneous: all four btn_n fall in the same cycle. Required response:
- press equals 4'b1111 for exactly one cycle.
- long_press equals 4'b1111 exactly 19 cycles later.
